// File: rtl/reg_list_sequencer.sv
// Load/store-multiple sequencer: walks a 16-bit register list one memory transfer per register.
// Define RLS_WRITEBACK_EN to include the base-writeback (WB) state; otherwise W is ignored.
module reg_list_sequencer #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          L,
  input  logic          U,
  input  logic          P,
  input  logic          W,
  input  logic [15:0]   RLIST,
  input  logic [3:0]    RN,
  input  logic [DW-1:0] BASE,
  input  logic          MEM_RDY,
  input  logic [DW-1:0] MEM_RD_DATA,
  input  logic [DW-1:0] PD,
  output logic          BUSY,
  output logic          DONE,
  output logic          MEM_EN,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WR_DATA,
  output logic [3:0]    SD,
  output logic [3:0]    C,
  output logic [DW-1:0] PW,
  output logic          RFLd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [4:0] f_popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] f_lowest(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  state_t        r_state, w_next;
  logic          r_l, r_u, r_p, r_w, r_wb;
  logic [15:0]   r_mask;
  logic [3:0]    r_rn;
  logic [DW-1:0] r_base, r_addr, r_final;

  logic [4:0]    w_cnt;
  logic [DW-1:0] w_n4, w_start, w_final;
  logic [3:0]    w_cur;
  logic          w_last, w_wb_ok;

  assign w_cnt   = f_popcount(r_mask);
  assign w_n4    = DW'({w_cnt, 2'b00});
  assign w_start = r_u ? (r_p ? r_base + DW'(32'd4) : r_base)
                       : (r_p ? r_base - w_n4 : r_base - w_n4 + DW'(32'd4));
  assign w_final = r_u ? r_base + w_n4 : r_base - w_n4;
  assign w_cur   = f_lowest(r_mask);
  assign w_last  = (r_mask & (r_mask - 16'd1)) == 16'd0;
  // A loaded base register must keep its loaded value, so writeback is dropped then.
`ifdef RLS_WRITEBACK_EN
  assign w_wb_ok = r_w && (r_mask != 16'd0) && !(r_l && r_mask[r_rn]);
`else
  assign w_wb_ok = r_w & 1'b0;
`endif
  assign MEM_WR_DATA = PD;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_l     <= 1'b0;
      r_u     <= 1'b0;
      r_p     <= 1'b0;
      r_w     <= 1'b0;
      r_wb    <= 1'b0;
      r_mask  <= 16'd0;
      r_rn    <= 4'd0;
      r_base  <= '0;
      r_addr  <= '0;
      r_final <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_l    <= L;
            r_u    <= U;
            r_p    <= P;
            r_w    <= W;
            r_mask <= RLIST;
            r_rn   <= RN;
            r_base <= BASE;
          end
        end
        S_SETUP: begin
          r_addr  <= w_start;
          r_final <= w_final;
          r_wb    <= w_wb_ok;
        end
        S_XFER: begin
          if (MEM_RDY) begin
            r_mask <= r_mask & (r_mask - 16'd1);
            r_addr <= r_addr + DW'(32'd4);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_next   = r_state;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    MEM_EN   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    SD       = 4'd0;
    C        = 4'd0;
    PW       = '0;
    RFLd     = 1'b0;
    case (r_state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) w_next = S_SETUP;
      end
      S_SETUP: begin
        w_next = (r_mask == 16'd0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        MEM_EN   = 1'b1;
        MEM_WE   = ~r_l;
        MEM_ADDR = r_addr;
        SD       = w_cur;
        if (MEM_RDY) begin
          if (r_l) begin
            RFLd = 1'b1;
            C    = w_cur;
            PW   = MEM_RD_DATA;
          end
          if (w_last) w_next = r_wb ? S_WB : S_DONE;
        end
      end
      S_WB: begin
        RFLd   = 1'b1;
        C      = r_rn;
        PW     = r_final;
        w_next = S_DONE;
      end
      S_DONE: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        BUSY   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed bench for reg_list_sequencer; expectations are hand-computed per cycle.
module tb_reg_list_sequencer;
  logic        CLK = 1'b0;
  logic        RST, START, L, U, P, W, MEM_RDY;
  logic [15:0] RLIST;
  logic [3:0]  RN;
  logic [31:0] BASE, MEM_RD_DATA, PD;
  logic        BUSY, DONE, MEM_EN, MEM_WE, RFLd;
  logic [31:0] MEM_ADDR, MEM_WR_DATA, PW;
  logic [3:0]  SD, C;
  int n_errs = 0;
  int n_checks = 0;

  always #5 CLK = ~CLK;

  reg_list_sequencer #(.DW(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .L(L), .U(U), .P(P), .W(W),
    .RLIST(RLIST), .RN(RN), .BASE(BASE), .MEM_RDY(MEM_RDY),
    .MEM_RD_DATA(MEM_RD_DATA), .PD(PD), .BUSY(BUSY), .DONE(DONE),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WR_DATA(MEM_WR_DATA), .SD(SD), .C(C), .PW(PW), .RFLd(RFLd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic busy, input logic done,
                         input logic en, input logic we, input logic rfld,
                         input logic [31:0] addr, input logic [3:0] sd,
                         input logic [3:0] c, input logic [31:0] pw);
    chk({tag, ".busy"}, {31'd0, BUSY},   {31'd0, busy});
    chk({tag, ".done"}, {31'd0, DONE},   {31'd0, done});
    chk({tag, ".en"},   {31'd0, MEM_EN}, {31'd0, en});
    chk({tag, ".we"},   {31'd0, MEM_WE}, {31'd0, we});
    chk({tag, ".rfld"}, {31'd0, RFLd},   {31'd0, rfld});
    chk({tag, ".addr"}, MEM_ADDR, addr);
    chk({tag, ".sd"},   {28'd0, SD}, {28'd0, sd});
    chk({tag, ".c"},    {28'd0, C},  {28'd0, c});
    chk({tag, ".pw"},   PW, pw);
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic cmd(input logic l, input logic u, input logic p, input logic w,
                     input logic [15:0] rl, input logic [3:0] rn, input logic [31:0] base);
    START = 1'b1; L = l; U = u; P = p; W = w; RLIST = rl; RN = rn; BASE = base;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; L = 1'b0; U = 1'b0; P = 1'b0; W = 1'b0;
    RLIST = 16'd0; RN = 4'd0; BASE = 32'd0; MEM_RDY = 1'b0;
    MEM_RD_DATA = 32'd0; PD = 32'd0;
    next_cyc(); next_cyc(); sample();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); RST = 1'b0; sample();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Store, increment-after, three registers
    next_cyc(); cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0007, 4'd0, 32'h100);
    MEM_RDY = 1'b1; PD = 32'hA5A5_0001; sample();
    chk("t1.idle.busy", {31'd0, BUSY}, 32'd0);
    next_cyc(); START = 1'b0; sample();
    chk_out("t1.setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); sample();
      chk_out("t1.xfer", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 4'(i), 4'd0, 32'd0);
      chk("t1.wrdata", MEM_WR_DATA, 32'hA5A5_0001);
    end
    next_cyc(); sample();
    chk_out("t1.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Load, decrement-before, writeback request; START in first IDLE cycle
    next_cyc(); cmd(1'b1, 1'b0, 1'b1, 1'b1, 16'h8002, 4'd13, 32'h200); sample();
    chk_out("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); START = 1'b0; sample();
    chk_out("t2.setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); MEM_RD_DATA = 32'h1111_1111; sample();
    chk_out("t2.x0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1F8, 4'd1, 4'd1, 32'h1111_1111);
    next_cyc(); MEM_RD_DATA = 32'h2222_2222; sample();
    chk_out("t2.x1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1FC, 4'd15, 4'd15, 32'h2222_2222);
`ifdef RLS_WRITEBACK_EN
    next_cyc(); sample();
    chk_out("t2.wb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd0, 4'd13, 32'h1F8);
`endif
    next_cyc(); sample();
    chk_out("t2.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Load with three stall cycles
    next_cyc(); cmd(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 4'd0, 32'h300); MEM_RDY = 1'b0; sample();
    next_cyc(); START = 1'b0; sample();
    chk_out("t3.setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); sample();
      chk_out("t3.stall", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 4'd4, 4'd0, 32'd0);
    end
    next_cyc(); MEM_RDY = 1'b1; MEM_RD_DATA = 32'hDEAD_BEEF; sample();
    chk_out("t3.rdy", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 4'd4, 4'd4, 32'hDEAD_BEEF);
    next_cyc(); sample();
    chk_out("t3.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Empty list with writeback request
    next_cyc(); cmd(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd5, 32'h700); sample();
    next_cyc(); START = 1'b0; sample();
    chk_out("t4.setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); sample();
    chk_out("t4.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); sample();
    chk_out("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Load, increment-before, base register in list
    next_cyc(); cmd(1'b1, 1'b1, 1'b1, 1'b1, 16'h0009, 4'd3, 32'h400); sample();
    next_cyc(); START = 1'b0; sample();
    next_cyc(); MEM_RD_DATA = 32'hAAAA_0000; sample();
    chk_out("t5.x0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h404, 4'd0, 4'd0, 32'hAAAA_0000);
    next_cyc(); MEM_RD_DATA = 32'hBBBB_0003; sample();
    chk_out("t5.x1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h408, 4'd3, 4'd3, 32'hBBBB_0003);
    next_cyc(); sample();
    chk_out("t5.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Store, decrement-after, writeback request
    next_cyc(); cmd(1'b0, 1'b0, 1'b0, 1'b1, 16'h00F0, 4'd2, 32'h500); sample();
    next_cyc(); START = 1'b0; sample();
    for (int i = 0; i < 4; i++) begin
      next_cyc(); sample();
      chk_out("t6.xfer", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4F4 + 32'(4 * i), 4'(4 + i), 4'd0, 32'd0);
    end
`ifdef RLS_WRITEBACK_EN
    next_cyc(); sample();
    chk_out("t6.wb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 4'd0, 4'd2, 32'h4F0);
`endif
    next_cyc(); sample();
    chk_out("t6.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    // Reset during the second transfer of a four-register load
    next_cyc(); cmd(1'b1, 1'b1, 1'b0, 1'b0, 16'h000F, 4'd0, 32'h600); sample();
    next_cyc(); START = 1'b0; sample();
    next_cyc(); MEM_RD_DATA = 32'h0000_0005; sample();
    chk_out("t7.x0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 4'd0, 4'd0, 32'h0000_0005);
    next_cyc(); MEM_RDY = 1'b0; RST = 1'b1; sample();
    chk_out("t7.x1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h604, 4'd1, 4'd0, 32'd0);
    next_cyc(); RST = 1'b0; MEM_RDY = 1'b1;
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd0, 32'h800); sample();
    chk_out("t7.post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); START = 1'b0; sample();
    chk_out("t7.setup", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    next_cyc(); sample();
    chk_out("t7.xfer", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h800, 4'd0, 4'd0, 32'd0);
    next_cyc(); sample();
    chk_out("t7.done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
